// File: rtl/fp32_pkg.sv
// Shared fp32 definitions: converter state encoding, operand class codes and integer limits.
package fp32_pkg;

  typedef enum logic [3:0] {
    ST_START  = 4'd0,
    ST_EVAL   = 4'd1,
    ST_ALIGN  = 4'd2,
    ST_ROUND  = 4'd3,
    ST_SIGN   = 4'd4,
    ST_FINISH = 4'd5
  } state_e;

  typedef enum logic [1:0] {
    T_ZER = 2'd0,
    T_INF = 2'd1,
    T_NAN = 2'd2,
    T_NUM = 2'd3
  } fp_class_e;

  localparam int unsigned BIAS      = 127;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  // Denormals fold into T_ZER: they always convert to integer zero.
  function automatic fp_class_e fp_classify(input logic [7:0] exp_f, input logic [22:0] man_f);
    if (exp_f == 8'hFF) begin
      return (man_f != '0) ? T_NAN : T_INF;
    end else if (exp_f == 8'h00) begin
      return T_ZER;
    end
    return T_NUM;
  endfunction

endpackage

// File: rtl/fp_rne_shift.sv
// Aligns a 24-bit significand to integer position and extracts guard/sticky for RNE rounding.
module fp_rne_shift (
  input  logic        [23:0] sig,
  input  logic signed [9:0]  e,
  output logic        [31:0] mag,
  output logic               guard,
  output logic               sticky
);

  logic [47:0] ext;
  logic [2:0]  lsh;
  logic [4:0]  rsh;

  always_comb begin
    ext    = '0;
    mag    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    lsh    = 3'(e - 10'sd23);
    rsh    = 5'(10'sd23 - e);
    if (e >= 10'sd23) begin
      mag = {8'b0, sig} << lsh;
    end else if (e >= -10'sd1) begin
      // Shifted-out bits land in the low half; e = -1 leaves mag = 0 and guard = hidden bit.
      ext    = {sig, 24'b0} >> rsh;
      mag    = {8'b0, ext[47:24]};
      guard  = ext[23];
      sticky = |ext[22:0];
    end
  end

endmodule

// File: rtl/fp32_to_int32.sv
// Multi-cycle fp32 to int32 converter with round-to-nearest-even and saturation flags.
module fp32_to_int32
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [31:0] op,
  output logic [31:0] res,
  output logic        done,
  output logic        busy,
  output logic        invalid,
  output logic        inexact
);

  state_e      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [31:0] work_q, work_d;
  logic        w_inv_q, w_inv_d;
  logic        w_inx_q, w_inx_d;
  logic [31:0] res_q, res_d;
  logic        done_q, done_d;
  logic        invalid_q, invalid_d;
  logic        inexact_q, inexact_d;

  logic               op_sign;
  logic        [7:0]  op_exp;
  logic        [22:0] op_man;
  logic        [9:0]  exp_diff;
  logic signed [9:0]  unb_exp;
  fp_class_e          op_class;
  logic               too_big;
  logic               too_small;
  logic               special;
  logic        [31:0] sh_mag;
  logic               sh_guard;
  logic               sh_sticky;
  logic               round_up;

  assign op_sign   = op_q[31];
  assign op_exp    = op_q[30:23];
  assign op_man    = op_q[22:0];
  assign exp_diff  = {2'b00, op_exp} - 10'(BIAS);
  assign unb_exp   = signed'(exp_diff);
  assign op_class  = fp_classify(op_exp, op_man);
  assign too_big   = unb_exp >= 10'sd31;
  assign too_small = unb_exp <= -10'sd2;
  assign special   = (op_class != T_NUM) || too_big || too_small;
  assign round_up  = guard_q & (sticky_q | mag_q[0]);

  fp_rne_shift u_shift (
    .sig    ({1'b1, op_man}),
    .e      (unb_exp),
    .mag    (sh_mag),
    .guard  (sh_guard),
    .sticky (sh_sticky)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START:  if (ready) state_d = ST_EVAL;
      ST_EVAL:   state_d = special ? ST_FINISH : ST_ALIGN;
      ST_ALIGN:  state_d = ST_ROUND;
      ST_ROUND:  state_d = ST_SIGN;
      ST_SIGN:   state_d = ST_FINISH;
      ST_FINISH: state_d = ST_START;
      default:   state_d = ST_START;
    endcase
  end

  // Datapath next-state: each state owns the registers it advances.
  always_comb begin
    op_d     = op_q;
    mag_d    = mag_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    work_d   = work_q;
    w_inv_d  = w_inv_q;
    w_inx_d  = w_inx_q;
    case (state_q)
      ST_START: if (ready) op_d = op;
      ST_EVAL: begin
        unique case (op_class)
          T_NAN: begin
            work_d  = INT32_MAX;
            w_inv_d = 1'b1;
            w_inx_d = 1'b0;
          end
          T_INF: begin
            work_d  = op_sign ? INT32_MIN : INT32_MAX;
            w_inv_d = 1'b1;
            w_inx_d = 1'b0;
          end
          T_ZER: begin
            work_d  = '0;
            w_inv_d = 1'b0;
            w_inx_d = (op_man != '0);
          end
          T_NUM: begin
            if (too_big) begin
              // -2^31 is the one value at e = 31 that fits exactly.
              if (op_sign && (unb_exp == 10'sd31) && (op_man == '0)) begin
                work_d  = INT32_MIN;
                w_inv_d = 1'b0;
              end else begin
                work_d  = op_sign ? INT32_MIN : INT32_MAX;
                w_inv_d = 1'b1;
              end
              w_inx_d = 1'b0;
            end else if (too_small) begin
              work_d  = '0;
              w_inv_d = 1'b0;
              w_inx_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_ALIGN: begin
        mag_d    = sh_mag;
        guard_d  = sh_guard;
        sticky_d = sh_sticky;
      end
      ST_ROUND: begin
        mag_d   = mag_q + {31'b0, round_up};
        w_inv_d = 1'b0;
        w_inx_d = guard_q | sticky_q;
      end
      ST_SIGN:  work_d = op_sign ? (~mag_q + 32'd1) : mag_q;
      default: ;
    endcase
  end

  always_comb begin
    res_d     = res_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;
    done_d    = 1'b0;
    if (state_q == ST_FINISH) begin
      res_d     = work_q;
      invalid_d = w_inv_q;
      inexact_d = w_inx_q;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      mag_q     <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      work_q    <= '0;
      w_inv_q   <= 1'b0;
      w_inx_q   <= 1'b0;
      res_q     <= '0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      mag_q     <= mag_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      work_q    <= work_d;
      w_inv_q   <= w_inv_d;
      w_inx_q   <= w_inx_d;
      res_q     <= res_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
    end
  end

  assign res     = res_q;
  assign done    = done_q;
  assign invalid = invalid_q;
  assign inexact = inexact_q;
  assign busy    = (state_q != ST_START);

endmodule
